// File: rtl/axis_fifo_bridge.sv
// rtl/axis_fifo_bridge.sv - CPU register window bridging per-channel TX/RX FIFOs to AXI-stream master/slave ports
module axis_fifo_bridge #(
    parameter int          CHANNELS   = 2,
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'hE4000000
) (
    input  logic                           axis_aclk_i,
    input  logic                           axis_aresetn_i,
    input  logic [31:0]                    addr_i,
    input  logic [31:0]                    data_i,
    output logic [31:0]                    data_o,
    output logic                           data_access_o,
    input  logic                           data_w_i,
    input  logic [CHANNELS-1:0]            m_axis_tready_i,
    output logic [CHANNELS-1:0]            m_axis_tvalid_o,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [CHANNELS-1:0]            s_axis_tready_o,
    input  logic [CHANNELS-1:0]            s_axis_tvalid_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                           irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [4:0]    CH_LIM   = 5'(CHANNELS);

    logic       hit_w, wr_hit_w, rd_hit_w;
    logic [3:0] ch_sel_w;
    logic [1:0] reg_sel_w;
    logic       unused_w;

    assign ch_sel_w      = addr_i[7:4];
    assign reg_sel_w     = addr_i[3:2];
    assign hit_w         = (addr_i[31:8] == BASE_ADDR[31:8]) && ({1'b0, ch_sel_w} < CH_LIM);
    assign wr_hit_w      = hit_w & data_w_i;
    assign rd_hit_w      = hit_w & ~data_w_i;
    assign data_access_o = hit_w;
    assign unused_w      = ^{addr_i[1:0], data_i[31:10]};

    logic [31:0]         status_w [CHANNELS];
    logic [31:0]         ctrl_rd_w [CHANNELS];
    logic [31:0]         rx_rd_w [CHANNELS];
    logic [CHANNELS-1:0] irq_ch_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [3:0] CH_ID = 4'(c);

        logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
        logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
        logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
        logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
        logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
        logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
        logic rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
        logic sel_w, ctrl_wr_w, tx_push_w, tx_push_ok_w, tx_pop_w;
        logic rx_push_w, rx_pop_req_w, rx_pop_w;
        logic tx_flush_w, rx_flush_w, clr_w;

        assign sel_w        = ch_sel_w == CH_ID;
        assign ctrl_wr_w    = wr_hit_w && sel_w && reg_sel_w == 2'd3;
        assign tx_push_w    = wr_hit_w && sel_w && reg_sel_w == 2'd0;
        assign rx_pop_req_w = rd_hit_w && sel_w && reg_sel_w == 2'd1;
        assign tx_flush_w   = ctrl_wr_w & data_i[0];
        assign rx_flush_w   = ctrl_wr_w & data_i[1];
        assign clr_w        = ctrl_wr_w & data_i[2];
        // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues an overflowing push
        assign tx_push_ok_w = tx_push_w && (tx_cnt_q != FULL_CNT);
        assign tx_pop_w     = (tx_cnt_q != '0) && m_axis_tready_i[c];
        assign rx_push_w    = s_axis_tvalid_i[c] && (rx_cnt_q != FULL_CNT);
        assign rx_pop_w     = rx_pop_req_w && (rx_cnt_q != '0);

        always_comb begin
            tx_wr_d  = tx_wr_q;
            tx_rd_d  = tx_rd_q;
            tx_cnt_d = tx_cnt_q;
            rx_wr_d  = rx_wr_q;
            rx_rd_d  = rx_rd_q;
            rx_cnt_d = rx_cnt_q;
            tx_ovf_d = tx_ovf_q;
            rx_udf_d = rx_udf_q;
            rx_ie_d  = rx_ie_q;
            tx_ie_d  = tx_ie_q;
            if (tx_push_ok_w) tx_wr_d = tx_wr_q + PTR_ONE;
            if (tx_pop_w)     tx_rd_d = tx_rd_q + PTR_ONE;
            case ({tx_push_ok_w, tx_pop_w})
                2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
                2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
                default: tx_cnt_d = tx_cnt_q;
            endcase
            if (rx_push_w) rx_wr_d = rx_wr_q + PTR_ONE;
            if (rx_pop_w)  rx_rd_d = rx_rd_q + PTR_ONE;
            case ({rx_push_w, rx_pop_w})
                2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
                2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
                default: rx_cnt_d = rx_cnt_q;
            endcase
            // Flush overrides any push/pop on the same edge
            if (tx_flush_w) begin
                tx_wr_d  = '0;
                tx_rd_d  = '0;
                tx_cnt_d = '0;
            end
            if (rx_flush_w) begin
                rx_wr_d  = '0;
                rx_rd_d  = '0;
                rx_cnt_d = '0;
            end
            if (clr_w) begin
                tx_ovf_d = 1'b0;
                rx_udf_d = 1'b0;
            end else begin
                if (tx_push_w && !tx_push_ok_w)  tx_ovf_d = 1'b1;
                if (rx_pop_req_w && !rx_pop_w)   rx_udf_d = 1'b1;
            end
            if (ctrl_wr_w) begin
                rx_ie_d = data_i[8];
                tx_ie_d = data_i[9];
            end
        end

        always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
            if (!axis_aresetn_i) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_cnt_q <= '0;
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_cnt_q <= '0;
                tx_ovf_q <= 1'b0;
                rx_udf_q <= 1'b0;
                rx_ie_q  <= 1'b0;
                tx_ie_q  <= 1'b0;
            end else begin
                tx_wr_q  <= tx_wr_d;
                tx_rd_q  <= tx_rd_d;
                tx_cnt_q <= tx_cnt_d;
                rx_wr_q  <= rx_wr_d;
                rx_rd_q  <= rx_rd_d;
                rx_cnt_q <= rx_cnt_d;
                tx_ovf_q <= tx_ovf_d;
                rx_udf_q <= rx_udf_d;
                rx_ie_q  <= rx_ie_d;
                tx_ie_q  <= tx_ie_d;
            end
        end

        always_ff @(posedge axis_aclk_i) begin
            if (tx_push_ok_w) tx_mem_q[tx_wr_q] <= data_i[DATA_WIDTH-1:0];
            if (rx_push_w)    rx_mem_q[rx_wr_q] <= s_axis_tdata_i[c*DATA_WIDTH +: DATA_WIDTH];
        end

        assign m_axis_tvalid_o[c] = tx_cnt_q != '0;
        assign m_axis_tdata_o[c*DATA_WIDTH +: DATA_WIDTH] = tx_mem_q[tx_rd_q];
        assign s_axis_tready_o[c] = rx_cnt_q != FULL_CNT;

        assign status_w[c] = {11'd0, 5'(rx_cnt_q), 3'd0, 5'(tx_cnt_q), 2'd0,
                              rx_udf_q, tx_ovf_q,
                              rx_cnt_q == FULL_CNT, rx_cnt_q == '0,
                              tx_cnt_q == FULL_CNT, tx_cnt_q == '0};
        assign ctrl_rd_w[c] = {22'd0, tx_ie_q, rx_ie_q, 8'd0};
        assign rx_rd_w[c]   = (rx_cnt_q != '0) ? 32'(rx_mem_q[rx_rd_q]) : 32'd0;
        assign irq_ch_w[c]  = (rx_ie_q && rx_cnt_q != '0) || (tx_ie_q && tx_cnt_q == '0);
    end

    logic [31:0] rd_val_w;
    logic [31:0] data_q, data_d;
    logic        irq_q, irq_d;

    always_comb begin
        rd_val_w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel_w == 4'(i)) begin
                case (reg_sel_w)
                    2'd1:    rd_val_w = rx_rd_w[i];
                    2'd2:    rd_val_w = status_w[i];
                    2'd3:    rd_val_w = ctrl_rd_w[i];
                    default: rd_val_w = '0;
                endcase
            end
        end
    end

    assign data_d = rd_hit_w ? rd_val_w : data_q;
    assign irq_d  = |irq_ch_w;

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            data_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            irq_q  <= irq_d;
        end
    end

    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_axis_fifo_bridge.sv
// tb/tb_axis_fifo_bridge.sv - queue-model bench for axis_fifo_bridge
module tb_axis_fifo_bridge;
    localparam int CH = 2;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam logic [31:0] B = 32'hE4000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   addr_i = '0, data_i = '0, data_o;
    logic          data_access_o, data_w_i = 1'b0, irq_o;
    logic [CH-1:0] m_tready = '0, m_tvalid, s_tready, s_tvalid = '0;
    logic [CH*DW-1:0] m_tdata, s_tdata = '0;

    always #5 clk = ~clk;

    axis_fifo_bridge #(.CHANNELS(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .BASE_ADDR(B)) dut (
        .axis_aclk_i(clk), .axis_aresetn_i(rst_n),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .data_access_o(data_access_o), .data_w_i(data_w_i),
        .m_axis_tready_i(m_tready), .m_axis_tvalid_o(m_tvalid), .m_axis_tdata_o(m_tdata),
        .s_axis_tready_o(s_tready), .s_axis_tvalid_i(s_tvalid), .s_axis_tdata_i(s_tdata),
        .irq_o(irq_o)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: queues per FIFO, updated once per rising edge
    logic [DW-1:0] tx_q [CH][$];
    logic [DW-1:0] rx_q [CH][$];
    logic [CH-1:0] m_ovf, m_udf, m_rxie, m_txie;
    logic [31:0]   exp_data;
    logic          exp_irq;
    int            tsz [CH];
    int            rsz [CH];
    logic          m_hit, irq_n;
    int            m_ch, m_rg;

    function automatic logic [31:0] status_of(input int t, input int r, input logic ovf, input logic udf);
        logic [31:0] s;
        s = '0;
        s[0] = (t == 0);
        s[1] = (t == D);
        s[2] = (r == 0);
        s[3] = (r == D);
        s[4] = ovf;
        s[5] = udf;
        s[12:8] = t[4:0];
        s[20:16] = r[4:0];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                tx_q[c].delete();
                rx_q[c].delete();
            end
            m_ovf = '0; m_udf = '0; m_rxie = '0; m_txie = '0;
            exp_data = '0;
            exp_irq = 1'b0;
        end else begin
            irq_n = 1'b0;
            for (int c = 0; c < CH; c++) begin
                tsz[c] = tx_q[c].size();
                rsz[c] = rx_q[c].size();
                if ((m_rxie[c] && rsz[c] != 0) || (m_txie[c] && tsz[c] == 0)) irq_n = 1'b1;
            end
            m_hit = (addr_i[31:8] == B[31:8]) && (int'(addr_i[7:4]) < CH);
            m_ch = int'(addr_i[7:4]);
            m_rg = int'(addr_i[3:2]);
            if (m_hit && !data_w_i) begin
                case (m_rg)
                    1: exp_data = (rsz[m_ch] != 0) ? 32'(rx_q[m_ch][0]) : 32'd0;
                    2: exp_data = status_of(tsz[m_ch], rsz[m_ch], m_ovf[m_ch], m_udf[m_ch]);
                    3: exp_data = {22'd0, m_txie[m_ch], m_rxie[m_ch], 8'd0};
                    default: exp_data = 32'd0;
                endcase
            end
            for (int c = 0; c < CH; c++) begin
                if (tsz[c] != 0 && m_tready[c]) void'(tx_q[c].pop_front());
                if (rsz[c] != D && s_tvalid[c]) rx_q[c].push_back(s_tdata[c*DW +: DW]);
            end
            if (m_hit && !data_w_i && m_rg == 1) begin
                if (rsz[m_ch] != 0) void'(rx_q[m_ch].pop_front());
                else m_udf[m_ch] = 1'b1;
            end
            if (m_hit && data_w_i && m_rg == 0) begin
                if (tsz[m_ch] == D) m_ovf[m_ch] = 1'b1;
                else tx_q[m_ch].push_back(data_i[DW-1:0]);
            end
            if (m_hit && data_w_i && m_rg == 3) begin
                if (data_i[0]) tx_q[m_ch].delete();
                if (data_i[1]) rx_q[m_ch].delete();
                if (data_i[2]) begin
                    m_ovf[m_ch] = 1'b0;
                    m_udf[m_ch] = 1'b0;
                end
                m_rxie[m_ch] = data_i[8];
                m_txie[m_ch] = data_i[9];
            end
            exp_irq = irq_n;
        end
    end

    logic [CH-1:0] ev, er;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < CH; c++) begin
                ev[c] = tx_q[c].size() != 0;
                er[c] = rx_q[c].size() != D;
                if (ev[c]) chk($sformatf("model m_tdata[%0d]", c), 32'(m_tdata[c*DW +: DW]), 32'(tx_q[c][0]));
            end
            chk("model m_tvalid", 32'(m_tvalid), 32'(ev));
            chk("model s_tready", 32'(s_tready), 32'(er));
            chk("model irq", 32'(irq_o), 32'(exp_irq));
            chk("model data_o", data_o, exp_data);
        end
    end

    task automatic cpu(input logic [31:0] a, input logic [31:0] d, input logic w, output logic [31:0] rd);
        @(negedge clk); #2;
        addr_i = a; data_i = d; data_w_i = w;
        @(negedge clk);
        rd = data_o;
        #2;
        addr_i = '0; data_i = '0; data_w_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        cpu(a, d, 1'b1, dummy);
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        cpu(a, 32'd0, 1'b0, v);
        chk(name, v, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset m_tvalid", 32'(m_tvalid), 32'd0);
        chk("reset s_tready", 32'(s_tready), 32'd3);
        chk("reset irq", 32'(irq_o), 32'd0);
        chk("reset data_o", data_o, 32'd0);
        #2 rst_n = 1'b1;
        rdchk("reset status ch0", B + 32'h8, 32'h5);

        // TX first-word fall-through and drain order on ch0
        wr(B, 32'h11); wr(B, 32'h22); wr(B, 32'h33);
        chk("tx0 valid held", 32'(m_tvalid[0]), 32'd1);
        chk("tx0 head", 32'(m_tdata[7:0]), 32'h11);
        @(negedge clk);
        chk("tx0 head stable", 32'(m_tdata[7:0]), 32'h11);
        #2 m_tready[0] = 1'b1;
        @(negedge clk); chk("tx0 word2", 32'(m_tdata[7:0]), 32'h22);
        @(negedge clk); chk("tx0 word3", 32'(m_tdata[7:0]), 32'h33);
        @(negedge clk); chk("tx0 drained", 32'(m_tvalid[0]), 32'd0);
        #2 m_tready[0] = 1'b0;

        // Overflow on ch1
        for (int i = 1; i <= 5; i++) wr(B + 32'h10, 32'(i));
        rdchk("tx1 full status", B + 32'h18, 32'h416);
        wr(B + 32'h1C, 32'h4);
        rdchk("tx1 ovf cleared", B + 32'h18, 32'h406);
        chk("tx1 word1", 32'(m_tdata[15:8]), 32'd1);
        m_tready[1] = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("tx1 drain word", 32'(m_tdata[15:8]), 32'(i));
        end
        @(negedge clk); chk("tx1 fifth dropped", 32'(m_tvalid[1]), 32'd0);
        #2 m_tready[1] = 1'b0;

        // RX fill and CPU reads on ch0
        @(negedge clk); #2 s_tvalid[0] = 1'b1; s_tdata[7:0] = 8'hA5;
        @(negedge clk); #2 s_tdata[7:0] = 8'h5A;
        @(negedge clk); #2 s_tvalid[0] = 1'b0;
        rdchk("rx0 count2", B + 32'h8, 32'h20001);
        rdchk("rx0 read1", B + 32'h4, 32'hA5);
        rdchk("rx0 read2", B + 32'h4, 32'h5A);
        rdchk("rx0 read empty", B + 32'h4, 32'h0);
        rdchk("rx0 udf status", B + 32'h8, 32'h25);
        wr(B + 32'hC, 32'h4);
        rdchk("rx0 udf cleared", B + 32'h8, 32'h5);

        // rx_ie interrupt timing on ch1
        wr(B + 32'h1C, 32'h100);
        rdchk("ctrl1 readback", B + 32'h1C, 32'h100);
        @(negedge clk); chk("irq idle", 32'(irq_o), 32'd0);
        #2 s_tvalid[1] = 1'b1; s_tdata[15:8] = 8'h3C;
        @(negedge clk); chk("irq before latency", 32'(irq_o), 32'd0);
        #2 s_tvalid[1] = 1'b0;
        @(negedge clk); chk("irq rx raised", 32'(irq_o), 32'd1);
        rdchk("rx1 read", B + 32'h14, 32'h3C);
        chk("irq still high", 32'(irq_o), 32'd1);
        @(negedge clk); chk("irq dropped", 32'(irq_o), 32'd0);
        wr(B + 32'h1C, 32'h0);

        // tx_ie interrupt on ch0 and a pass-through word
        wr(B + 32'hC, 32'h200);
        chk("irq tx pending", 32'(irq_o), 32'd0);
        @(negedge clk); chk("irq tx empty", 32'(irq_o), 32'd1);
        #2 m_tready[0] = 1'b1;
        wr(B, 32'h77);
        repeat (3) @(negedge clk);
        #2 m_tready[0] = 1'b0;
        wr(B + 32'hC, 32'h0);

        // Flushes
        wr(B, 32'hAA); wr(B, 32'hBB);
        chk("flush pre valid", 32'(m_tvalid[0]), 32'd1);
        wr(B + 32'hC, 32'h1);
        chk("flush tx valid", 32'(m_tvalid[0]), 32'd0);
        @(negedge clk); #2 s_tvalid[1] = 1'b1; s_tdata[15:8] = 8'h99;
        @(negedge clk); #2 s_tvalid[1] = 1'b0;
        wr(B + 32'h1C, 32'h2);
        rdchk("flush rx status", B + 32'h18, 32'h5);

        // Concurrent traffic on both channels plus CPU access
        for (int i = 0; i < 48; i++) begin
            @(negedge clk); #2;
            s_tvalid = 2'(i ^ (i >> 2));
            s_tdata  = 16'(i * 16'h0925 + 16'h0101);
            m_tready = 2'((i >> 1) ^ (i >> 3));
            case (i % 3)
                0: begin addr_i = B + 32'((i & 1) << 4);          data_i = 32'(i + 8'h40); data_w_i = 1'b1; end
                1: begin addr_i = B + 32'((i & 2) << 3) + 32'h4;  data_i = '0;             data_w_i = 1'b0; end
                default: begin addr_i = B + 32'((i & 1) << 4) + 32'h8; data_i = '0;        data_w_i = 1'b0; end
            endcase
        end
        @(negedge clk); #2;
        s_tvalid = '0; m_tready = '0; addr_i = '0; data_w_i = 1'b0;

        // Asynchronous reset with queued data, then decode boundaries
        wr(B + 32'hC, 32'h3);
        wr(B, 32'h01); wr(B, 32'h02); wr(B, 32'h03);
        chk("pre-reset valid", 32'(m_tvalid[0]), 32'd1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async reset tvalid", 32'(m_tvalid), 32'd0);
        chk("async reset s_tready", 32'(s_tready), 32'd3);
        addr_i = B + 32'h20; #1 chk("decode ch2 miss", 32'(data_access_o), 32'd0);
        addr_i = B + 32'h14; #1 chk("decode ch1 hit", 32'(data_access_o), 32'd1);
        addr_i = 32'hE5000000; #1 chk("decode base miss", 32'(data_access_o), 32'd0);
        addr_i = '0;
        @(negedge clk); #2 rst_n = 1'b1;
        rdchk("post-reset status", B + 32'h8, 32'h5);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axis_fifo_bridge.md
AXIS_FIFO_BRIDGE -- requirements
Module: axis_fifo_bridge

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of AXI-stream channel pairs (1..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, AXI-stream tdata width (8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per FIFO (power of 2, 2..16).
REQ-004 SHALL have parameter BASE_ADDR, default 32'hE4000000, CPU register window base.
REQ-005 SHALL have ports:
  axis_aclk_i  in  1  single clock, all logic on rising edge
  axis_aresetn_i  in  1  reset, asynchronous, active-low
  addr_i  in  32  CPU address
  data_i  in  32  CPU write data
  data_o  out  32  CPU read data, registered
  data_access_o  out  1  address hits a valid register
  data_w_i  in  1  CPU write strobe
  m_axis_tready_i  in  CHANNELS  per-channel master ready
  m_axis_tvalid_o  out  CHANNELS  per-channel master valid
  m_axis_tdata_o  out  CHANNELS*DATA_WIDTH  channel n at [n*DATA_WIDTH +: DATA_WIDTH]
  s_axis_tready_o  out  CHANNELS  per-channel slave ready
  s_axis_tvalid_i  in  CHANNELS  per-channel slave valid
  s_axis_tdata_i  in  CHANNELS*DATA_WIDTH  same packing as m_axis_tdata_o
  irq_o  out  1  registered interrupt request

Function
REQ-006 Decode: hit when addr_i[31:8]==BASE_ADDR[31:8] and addr_i[7:4]<CHANNELS; ch=addr_i[7:4], reg=addr_i[3:2]; data_access_o combinational from the decode.
REQ-007 Registers per channel: 0 TXDATA (W), 1 RXDATA (R), 2 STATUS (R), 3 CTRL (R/W); writes to RXDATA/STATUS and reads of TXDATA are ignored (TXDATA reads return 0).
REQ-008 Each channel SHALL have one TX FIFO and one RX FIFO, FIFO_DEPTH entries, circular pointers wrapping DEPTH-1 -> 0, count 0..FIFO_DEPTH.
REQ-009 TX push: hit on TXDATA with data_w_i=1 pushes data_i[DATA_WIDTH-1:0]; if count==FIFO_DEPTH at that edge, drop and set sticky tx_ovf, even if a pop occurs in the same cycle.
REQ-010 TX drain: m_axis_tvalid_o[ch]=(tx_count!=0); tdata = FIFO head (first-word fall-through); pop on tvalid&tready; tdata stable while tvalid=1 and tready=0.
REQ-011 RX fill: s_axis_tready_o[ch]=(rx_count!=FIFO_DEPTH); push on tvalid&tready.
REQ-012 RX read: hit on RXDATA with data_w_i=0 pops the head and loads it zero-extended into data_o; read when empty loads 0, no pop, sets sticky rx_udf.
REQ-013 A same-cycle push and pop on a non-full, non-empty FIFO SHALL leave count unchanged; on an empty FIFO the pushed word becomes the head.
REQ-014 STATUS: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_udf, [12:8] tx_count, [20:16] rx_count, other bits 0.
REQ-015 CTRL write: [0] flush TX, [1] flush RX, [2] clear tx_ovf/rx_udf (self-clearing actions), [8] rx_ie, [9] tx_ie stored; CTRL read returns rx_ie in [8], tx_ie in [9], other bits 0.
REQ-016 Flush SHALL zero pointers and count at the next edge and take priority over a same-cycle push or pop on that FIFO; m_axis_tvalid_o may drop without handshake (intentional abort).
REQ-017 Read latency: data_o is loaded at the edge ending the access cycle and holds until the next read hit; one access cycle = one pop.
REQ-018 irq_o registered: OR over channels of (rx_ie & !rx_empty) | (tx_ie & tx_empty), 1-cycle latency from the state change.
REQ-019 Channels SHALL be independent; simultaneous AXIS traffic on all channels plus one CPU access per cycle SHALL be supported.

Reset
REQ-020 On axis_aresetn_i=0, immediately: all counts/pointers 0, sticky flags 0, rx_ie=tx_ie=0, data_o=0, irq_o=0, m_axis_tvalid_o=0, s_axis_tready_o=all 1; FIFO contents are don't-care.
REQ-021 Reset asserted mid-transfer SHALL discard all queued data; first valid operation is at the first edge after release.

Verification
REQ-022 Write 0x11,0x22,0x33 to ch0 TXDATA with tready=0 -> tvalid=1, tdata=0x11 held; raise tready -> 0x11,0x22,0x33 on consecutive cycles, then tvalid=0.
REQ-023 DEPTH=4: 5 writes to ch1 TXDATA, tready=0 -> STATUS tx_full=1, tx_count=4, tx_ovf=1; 5th word never emitted; CTRL=0x4 clears tx_ovf.
REQ-024 Drive 0xA5,0x5A on ch0 slave -> rx_count=2; two RXDATA reads return 0xA5 then 0x5A one cycle after each access; third read returns 0, rx_udf=1.
REQ-025 CTRL rx_ie=1 on ch1, push one slave word -> irq_o=1 one cycle after rx_count becomes 1; read RXDATA -> irq_o=0 one cycle after empty.
REQ-026 Fill ch0 TX with 3 words, pulse axis_aresetn_i low -> tvalid=0 asynchronously, STATUS=0x5 after release; access to ch>=CHANNELS -> data_access_o=0.
